axil_clint: RTL

AXIL_CLINT -- requirements
Module: axil_clint

---
 rtl/axil_clint.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/axil_clint.sv
// axil_clint: AXI4-Lite slave exposing a free-running 64-bit mtime counter
// through an 8-byte window at BASE (low word at BASE, high word at BASE+4).
//
// Parameters
//   BASE : byte address of the 8-byte register window
//   DIV  : clk cycles per mtime increment (1..65535)
//
// Ports
//   clk, rst                          : clock and synchronous active-high reset
//   araddr/arvalid/arready            : read address channel
//   rdata/rresp/rvalid/rready         : read data channel
//   awaddr/awvalid/awready            : write address channel
//   wdata/wstrb/wvalid/wready         : write data channel
//   bresp/bvalid/bready               : write response channel
//
// Build option
//   CLINT_WRITE_EN : when defined, mapped writes update mtime and answer OKAY;
//                    otherwise mapped writes are ignored and answer SLVERR.
module axil_clint #(
   parameter logic [31:0] BASE = 32'ha000_0048,
   parameter int unsigned DIV  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] araddr,
   input  logic        arvalid,
   output logic        arready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rvalid,
   input  logic        rready,
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int unsigned PW = 16;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

`ifdef CLINT_WRITE_EN
   localparam bit WR_EN = 1'b1;
`else
   localparam bit WR_EN = 1'b0;
`endif

   typedef enum logic {R_IDLE, R_RESP} r_state_e;
   typedef enum logic {W_IDLE, W_RESP} w_state_e;

   // Timebase
   logic [63:0]   mtime_q, mtime_d;
   logic [PW-1:0] pre_q, pre_d;
   logic          tick;

   // Read channel
   r_state_e    r_state_q, r_state_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  rresp_q, rresp_d;
   logic        arready_q, rvalid_q;
   logic        rd_hit;
   logic [31:0] rd_word;

   // Write channel
   w_state_e    w_state_q, w_state_d;
   logic        aw_got_q, aw_got_d, w_got_q, w_got_d;
   logic [31:2] awaddr_q, awaddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [1:0]  bresp_q, bresp_d;
   logic        awready_q, wready_q, bvalid_q;
   logic        aw_hs, w_hs, commit, wr_hit;
   logic [31:2] cur_addr;
   logic [31:0] cur_data;
   logic [3:0]  cur_strb;
   logic [31:0] wr_half;

   // Byte-offset bits are don't-care in this register map.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{araddr[1:0], awaddr[1:0]};

   assign tick    = (pre_q == PW'(DIV - 1));
   assign rd_hit  = (araddr[31:3] == BASE[31:3]);
   assign rd_word = araddr[2] ? mtime_q[63:32] : mtime_q[31:0];

   // A beat is accepted only while idle and not already held.
   assign aw_hs    = (w_state_q == W_IDLE) && !aw_got_q && awvalid;
   assign w_hs     = (w_state_q == W_IDLE) && !w_got_q && wvalid;
   assign cur_addr = aw_got_q ? awaddr_q : awaddr[31:2];
   assign cur_data = w_got_q ? wdata_q : wdata;
   assign cur_strb = w_got_q ? wstrb_q : wstrb;
   assign commit   = (w_state_q == W_IDLE) && (aw_got_q || aw_hs) && (w_got_q || w_hs);
   assign wr_hit   = (cur_addr[31:3] == BASE[31:3]);

   // Addressed half with enabled byte lanes replaced.
   always_comb begin
      wr_half = cur_addr[2] ? mtime_q[63:32] : mtime_q[31:0];
      for (int b = 0; b < 4; b++) begin
         if (cur_strb[b]) wr_half[8*b +: 8] = cur_data[8*b +: 8];
      end
   end

   // Prescaler and mtime; a committing write wins over the increment.
   always_comb begin
      pre_d   = tick ? '0 : pre_q + PW'(1);
      mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
      if (WR_EN && commit && wr_hit) begin
         mtime_d = cur_addr[2] ? {wr_half, mtime_q[31:0]} : {mtime_q[63:32], wr_half};
      end
   end

   // Read FSM next state; data is captured at the AR handshake.
   always_comb begin
      r_state_d = r_state_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      unique case (r_state_q)
         R_IDLE: begin
            if (arvalid) begin
               r_state_d = R_RESP;
               rdata_d   = rd_hit ? rd_word : 32'd0;
               rresp_d   = rd_hit ? RESP_OKAY : RESP_DECERR;
            end
         end
         R_RESP: begin
            if (rready) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // Write FSM next state; AW and W are captured independently.
   always_comb begin
      w_state_d = w_state_q;
      aw_got_d  = aw_got_q;
      w_got_d   = w_got_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bresp_d   = bresp_q;
      unique case (w_state_q)
         W_IDLE: begin
            if (aw_hs) begin
               aw_got_d = 1'b1;
               awaddr_d = awaddr[31:2];
            end
            if (w_hs) begin
               w_got_d = 1'b1;
               wdata_d = wdata;
               wstrb_d = wstrb;
            end
            if (commit) begin
               w_state_d = W_RESP;
               if (!wr_hit)    bresp_d = RESP_DECERR;
               else if (WR_EN) bresp_d = RESP_OKAY;
               else            bresp_d = RESP_SLVERR;
            end
         end
         W_RESP: begin
            if (bready) begin
               w_state_d = W_IDLE;
               aw_got_d  = 1'b0;
               w_got_d   = 1'b0;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         mtime_q   <= '0;
         pre_q     <= '0;
         r_state_q <= R_IDLE;
         rdata_q   <= '0;
         rresp_q   <= '0;
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
         w_state_q <= W_IDLE;
         aw_got_q  <= 1'b0;
         w_got_q   <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bresp_q   <= '0;
         awready_q <= 1'b1;
         wready_q  <= 1'b1;
         bvalid_q  <= 1'b0;
      end else begin
         mtime_q   <= mtime_d;
         pre_q     <= pre_d;
         r_state_q <= r_state_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         arready_q <= (r_state_d == R_IDLE);
         rvalid_q  <= (r_state_d == R_RESP);
         w_state_q <= w_state_d;
         aw_got_q  <= aw_got_d;
         w_got_q   <= w_got_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bresp_q   <= bresp_d;
         awready_q <= (w_state_d == W_IDLE) && !aw_got_d;
         wready_q  <= (w_state_d == W_IDLE) && !w_got_d;
         bvalid_q  <= (w_state_d == W_RESP);
      end
   end

   assign arready = arready_q;
   assign rvalid  = rvalid_q;
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;
   assign awready = awready_q;
   assign wready  = wready_q;
   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;

endmodule
